// File: rtl/pipelined_addsub_pkg.sv
// rtl/pipelined_addsub_pkg.sv - shared operation encoding for the add/sub datapath
package pipelined_addsub_pkg;

    // SUB input encoding, shared with the ALU decoder
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/pipelined_addsub_if.sv
// rtl/pipelined_addsub_if.sv - operand/result handshake bundle for pipelined_addsub
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C0;
    logic             SUB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] SUM;
    logic             Cout;
    logic             Overflow;
    logic             Zero;

    modport master (
        output in_valid, A, B, C0, SUB, out_ready,
        input  in_ready, out_valid, SUM, Cout, Overflow, Zero
    );

    modport slave (
        input  in_valid, A, B, C0, SUB, out_ready,
        output in_ready, out_valid, SUM, Cout, Overflow, Zero
    );
endinterface

// File: rtl/pipelined_addsub_stage.sv
// rtl/pipelined_addsub_stage.sv - one CHUNK-bit slice adder with its pipeline register
module addsub_stage #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             carry_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);
    logic [CHUNK:0]   chunk_d;
    logic [WIDTH-1:0] sum_d;
    logic             valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    // Add this stage's slice and merge it into the partial sum from upstream
    always_comb begin
        chunk_d = {1'b0, a_i[IDX*CHUNK +: CHUNK]}
                + {1'b0, b_i[IDX*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, carry_i};
        sum_d   = sum_i;
        sum_d[IDX*CHUNK +: CHUNK] = chunk_d[CHUNK-1:0];
    end

    // Pipeline register; holds its contents whenever downstream is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= valid_i;
            a_q     <= a_i;
            b_q     <= b_i;
            sum_q   <= sum_d;
            carry_q <= chunk_d[CHUNK];
        end
    end

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign sum_o   = sum_q;
    assign carry_o = carry_q;
endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined adder/subtractor, one CHUNK-bit slice per stage
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic                clk,
    input logic                rst,
    pipelined_addsub_if.slave  bus
);
    // WIDTH must be a multiple of CHUNK
    localparam int STAGES = WIDTH / CHUNK;
    localparam int MSB    = WIDTH - 1;

    // Index k is the input of stage k; index STAGES is the last stage's register
    logic [STAGES:0] valid_w;
    logic [STAGES:0] carry_w;
    logic [STAGES:0] ready_w;
    logic [WIDTH-1:0] a_w   [0:STAGES];
    logic [WIDTH-1:0] b_w   [0:STAGES];
    logic [WIDTH-1:0] sum_w [0:STAGES];
    logic             unused_stage_data;

    // Subtraction enters as A + ~B + ~C0
    assign valid_w[0] = bus.in_valid;
    assign a_w[0]     = bus.A;
    assign b_w[0]     = (bus.SUB == OP_SUB) ? ~bus.B : bus.B;
    assign carry_w[0] = bus.C0 ^ (bus.SUB == OP_SUB);
    assign sum_w[0]   = '0;

    // Ready ripples back from the consumer; an empty stage always accepts
    always_comb begin
        ready_w         = '0;
        ready_w[STAGES] = bus.out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            ready_w[i] = !valid_w[i+1] || ready_w[i+1];
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        addsub_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (i)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .load_i  (ready_w[i]),
            .valid_i (valid_w[i]),
            .a_i     (a_w[i]),
            .b_i     (b_w[i]),
            .sum_i   (sum_w[i]),
            .carry_i (carry_w[i]),
            .valid_o (valid_w[i+1]),
            .a_o     (a_w[i+1]),
            .b_o     (b_w[i+1]),
            .sum_o   (sum_w[i+1]),
            .carry_o (carry_w[i+1])
        );
    end

    // Flags come from the last stage's registers; carry into the MSB is a^b^sum there
    assign bus.in_ready  = ready_w[0];
    assign bus.out_valid = valid_w[STAGES];
    assign bus.SUM       = sum_w[STAGES];
    assign bus.Cout      = carry_w[STAGES];
    assign bus.Overflow  = valid_w[STAGES]
                         & (a_w[STAGES][MSB] ^ b_w[STAGES][MSB] ^ sum_w[STAGES][MSB] ^ carry_w[STAGES]);
    assign bus.Zero      = valid_w[STAGES] && (sum_w[STAGES] == '0);

    assign unused_stage_data = ^{a_w[STAGES], b_w[STAGES]};
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub
module tb_pipelined_addsub;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_addsub_if #(.WIDTH(32)) b32 ();
    pipelined_addsub_if #(.WIDTH(16)) b16 ();
    pipelined_addsub_if #(.WIDTH(64)) b64 ();

    pipelined_addsub #(.WIDTH(32), .CHUNK(8))  dut32 (.clk(clk), .rst(rst), .bus(b32));
    pipelined_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    pipelined_addsub #(.WIDTH(64), .CHUNK(4))  dut64 (.clk(clk), .rst(rst), .bus(b64));

    logic [34:0] res32;
    logic [18:0] res16;
    logic [66:0] res64;
    assign res32 = {b32.Zero, b32.Overflow, b32.Cout, b32.SUM};
    assign res16 = {b16.Zero, b16.Overflow, b16.Cout, b16.SUM};
    assign res64 = {b64.Zero, b64.Overflow, b64.Cout, b64.SUM};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic, result packed as {Zero, Overflow, Cout, SUM}
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic c0, input logic sub);
        longint sr, ur;
        logic [31:0] s;
        logic cout, ovf;
        if (sub) begin
            sr   = longint'($signed(a)) - longint'($signed(b)) - longint'(c0);
            ur   = longint'(a) - longint'(b) - longint'(c0);
            cout = (ur >= 0);
        end else begin
            sr   = longint'($signed(a)) + longint'($signed(b)) + longint'(c0);
            ur   = longint'(a) + longint'(b) + longint'(c0);
            cout = (ur > longint'(32'hFFFF_FFFF));
        end
        s   = ur[31:0];
        ovf = (sr != longint'($signed(s)));
        return {(s == 32'h0), ovf, cout, s};
    endfunction

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic c0,
                        input logic sub, input logic [34:0] exp, input string tag);
        int lat;
        @(negedge clk);
        b32.A = a; b32.B = b; b32.C0 = c0; b32.SUB = sub;
        b32.in_valid = 1'b1; b32.out_ready = 1'b1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        lat = 1;
        while (!b32.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk({tag, " latency"}, lat, 4);
        chk(tag, res32, exp);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c0,
                        input logic sub, input logic [18:0] exp, input string tag);
        int lat;
        @(negedge clk);
        b16.A = a; b16.B = b; b16.C0 = c0; b16.SUB = sub;
        b16.in_valid = 1'b1; b16.out_ready = 1'b1;
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        lat = 1;
        while (!b16.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk({tag, " latency"}, lat, 1);
        chk(tag, res16, exp);
    endtask

    task automatic op64(input logic [63:0] a, input logic [63:0] b, input logic c0,
                        input logic sub, input logic [66:0] exp, input string tag);
        int lat;
        @(negedge clk);
        b64.A = a; b64.B = b; b64.C0 = c0; b64.SUB = sub;
        b64.in_valid = 1'b1; b64.out_ready = 1'b1;
        @(posedge clk); #1;
        b64.in_valid = 1'b0;
        lat = 1;
        while (!b64.out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
        chk({tag, " latency"}, lat, 16);
        chk(tag, res64, exp);
    endtask

    initial begin
        logic [34:0] q[$];
        logic [35:0] held;
        logic        stall_prev;
        int          sent, rcv, cyc;

        rst = 1'b1;
        b32.in_valid = 1'b0; b32.out_ready = 1'b1; b32.A = '0; b32.B = '0; b32.C0 = 1'b0; b32.SUB = 1'b0;
        b16.in_valid = 1'b0; b16.out_ready = 1'b1; b16.A = '0; b16.B = '0; b16.C0 = 1'b0; b16.SUB = 1'b0;
        b64.in_valid = 1'b0; b64.out_ready = 1'b1; b64.A = '0; b64.B = '0; b64.C0 = 1'b0; b64.SUB = 1'b0;

        // Outputs while held in reset
        #12;
        chk("reset out32", {b32.out_valid, b32.in_ready, res32}, {1'b0, 1'b1, 35'h0});
        chk("reset out16", {b16.out_valid, b16.in_ready, res16}, {1'b0, 1'b1, 19'h0});
        chk("reset out64", {b64.out_valid, b64.in_ready, res64}, {1'b0, 1'b1, 67'h0});
        @(negedge clk);
        rst = 1'b0;

        // Directed corners on the 32/8 instance
        op32(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 32'h0},         "wrap add");
        op32(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 32'h8000_0000}, "signed ovf add");
        op32(32'd5, 32'd7, 1'b0, 1'b1,          {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE}, "sub borrow");
        op32(32'd7, 32'd5, 1'b1, 1'b1,          {1'b0, 1'b0, 1'b1, 32'h1},         "sub with borrow-in");
        op32(32'h8000_0000, 32'h1, 1'b0, 1'b1,  {1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF}, "signed ovf sub");

        // Width/depth sweep
        op16(16'hFFFF, 16'h1, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0},    "w16 wrap add");
        op16(16'h7FFF, 16'h1, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 16'h8000}, "w16 signed ovf");
        op64(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 64'h0}, "w64 wrap add");
        op64(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
             {1'b0, 1'b1, 1'b0, 64'h8000_0000_0000_0000}, "w64 signed ovf");

        // Random traffic with random backpressure against an in-order scoreboard
        sent = 0; rcv = 0; cyc = 0; stall_prev = 1'b0; held = '0;
        while ((sent < 200 || rcv < 200) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            b32.in_valid  = (sent < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
            b32.A         = $urandom();
            b32.B         = ($urandom_range(0, 7) == 0) ? b32.A : $urandom();
            b32.C0        = 1'($urandom_range(0, 1));
            b32.SUB       = 1'($urandom_range(0, 1));
            b32.out_ready = 1'($urandom_range(0, 1));
            #1;
            chk("in_ready vs occupancy", b32.in_ready, !(q.size() == 4 && !b32.out_ready));
            if (stall_prev) chk("stall hold", {b32.out_valid, res32}, held);
            if (b32.out_valid && b32.out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious result", b32.out_valid, 1'b0);
                end else begin
                    chk("random result", res32, q.pop_front());
                    rcv++;
                end
            end
            if (b32.in_valid && b32.in_ready) begin
                q.push_back(model(b32.A, b32.B, b32.C0, b32.SUB));
                sent++;
            end
            stall_prev = b32.out_valid && !b32.out_ready;
            held       = {b32.out_valid, res32};
        end
        chk("random results received", rcv, 200);
        @(negedge clk); #1;
        chk("drained", b32.out_valid, 1'b0);

        // Asynchronous reset with three operations in flight
        @(negedge clk);
        b32.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b32.A = 32'(k + 1); b32.B = 32'h1; b32.C0 = 1'b0; b32.SUB = 1'b0;
            b32.in_valid = 1'b1;
            @(negedge clk);
        end
        b32.in_valid = 1'b0;
        @(posedge clk); #2;
        chk("first result before reset", {b32.out_valid, res32}, {1'b1, 35'h2});
        rst = 1'b1;
        #1;
        chk("mid-cycle reset outputs", {b32.out_valid, b32.in_ready, res32}, {1'b0, 1'b1, 35'h0});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        b32.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            chk("no stale result", b32.out_valid, 1'b0);
        end
        op32(32'd100, 32'd23, 1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 32'd124}, "after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end
endmodule
